// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table checker.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } tt_state_t;

    // Number of input vectors for an n-input function.
    function automatic int unsigned n_vec(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Per-vector hold counter; strobes sample on the last cycle of each vector.
module tt_hold_timer #(
    parameter int unsigned HOLD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic sample
);

    localparam int unsigned CW = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] LastCnt = CW'(HOLD - 1);

    logic [CW-1:0] hold_cnt;

    assign sample = en && (hold_cnt == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (restart) begin
            hold_cnt <= '0;
        end else if (en) begin
            if (hold_cnt == LastCnt) hold_cnt <= '0;
            else                     hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors of a small combinational block and checks its truth table.
// Define STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    parameter int unsigned HOLD = 2,
    parameter logic [n_vec(N_IN)-1:0] EXPECT = 8'hEA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   f,
    output logic [N_IN-1:0]        x,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [n_vec(N_IN)-1:0] captured,
    output logic [N_IN-1:0]        fail_idx
);

    localparam int unsigned NV = n_vec(N_IN);
    localparam logic [N_IN-1:0] LastVec = N_IN'(NV - 1);

`ifdef STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    tt_state_t state;
    logic      fail_q;
    logic      start_ok;
    logic      sample;
    logic      mismatch;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign mismatch = (f != EXPECT[x]);

    tt_hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_ok),
        .en      (state == DRIVE),
        .sample  (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            captured <= '0;
            fail_idx <= '0;
            fail_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state    <= DRIVE;
                        x        <= '0;
                        captured <= '0;
                        fail_idx <= '0;
                        fail_q   <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        captured[x] <= f;
                        if (mismatch && !fail_q) begin
                            fail_q   <= 1'b1;
                            fail_idx <= x;
                        end
                        // x is left on the vector that ended the sweep
                        if ((StopOnFail && mismatch) || x == LastVec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !(fail_q || mismatch);
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Hardware counterpart to a stimulus bench for small combinational blocks. It drives every input combination of an N_IN-input function under test in ascending order and holds each vector for HOLD cycles. It samples the function output once per vector, builds the captured truth table, and compares it against an expected table. It sits beside the combinational block as an on-chip self-checker: the block is wired to x, and the block's output is wired back to f.

Parameters:
N_IN, 3, number of function inputs (1..6)
HOLD, 2, clock cycles each vector is held; must be >= 1
EXPECT, 8'hEA, expected truth table, width 2**N_IN; bit i = expected f for vector i

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
f  in  1  output of function under test
x  out  N_IN  current input vector; x[N_IN-1] is the MSB (x1 of a 3-input block)
busy  out  1  high while a sweep is in progress
done  out  1  high from sweep completion until the next accepted start
pass  out  1  valid while done: 1 if captured == EXPECT
captured  out  2**N_IN  sampled truth table; bit i = f sampled for vector i
fail_idx  out  N_IN  lowest mismatching vector index; valid while done && !pass

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - x, captured, fail_idx, hold_cnt = 0.
  - busy, done, pass = 0.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - On the same edge: x=0, hold_cnt=0, captured=0, fail flag cleared, busy=1.
- DRIVE:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD-1, f is sampled into captured[x] on that edge.
  - On the same edge, the sampled bit is compared with EXPECT[x]. On the first mismatch only, fail_idx=x and the fail flag is set.
  - If x == 2**N_IN-1 on that edge -> DONE. Otherwise x increments and hold_cnt returns to 0.
  - With HOLD=1, f is sampled every cycle, and f must settle combinationally within one cycle.
- Sweep length: exactly 2**N_IN * HOLD cycles with busy=1.
- DONE:
  - busy=0, done=1, pass = !fail flag.
  - x holds the last vector.
  - start=1 -> behaves as the IDLE start: done=0, pass=0, and a new sweep begins.
- start while busy is ignored; the sweep is not restarted.
- Reset mid-sweep aborts immediately to reset values. No partial result is kept.
- x changes only on the edge after a sample, so the function under test sees each vector for exactly HOLD full cycles.
- Width rules:
  - x wraps naturally at 2**N_IN-1, but the wrap is never reached because DONE is taken first.
  - hold_cnt width is clog2(HOLD)+1.

Optional Feature:
Macro STOP_ON_FAIL_EN.
- Defined: on the first mismatch the FSM goes to DONE on the same sample edge.
  - pass=0; fail_idx = the failing vector; x stays at that vector.
  - captured holds the bits sampled so far; unsampled bits stay 0.
- Undefined: the sweep always runs all vectors.
  - fail_idx = the lowest mismatching index; captured is the full table.

Decomposition:
- Package tt_pkg holds:
  - state enum tt_state_t {IDLE, DRIVE, DONE};
  - localparam-style function n_vec(N_IN) = 2**N_IN.
- One natural sub-module, tt_hold_timer:
  - holds hold_cnt;
  - outputs a one-cycle sample strobe when hold_cnt==HOLD-1;
  - cleared by a restart input.

Test Plan:
- Defaults, function f=x1&x2|x3, start pulsed 1 cycle:
  - busy for 16 cycles; x steps 0..7, changing every 2 cycles;
  - then done=1, captured=8'hEA, pass=1.
- Same run with f forced to 0 on vector 5 (fault injection), STOP_ON_FAIL_EN undefined:
  - captured=8'hCA, pass=0, fail_idx=5, 16 busy cycles.
- Same fault with STOP_ON_FAIL_EN defined:
  - done after 12 busy cycles; fail_idx=5, x=5, captured=8'h0A, pass=0.
- start re-pulsed at cycle 6 of a sweep:
  - ignored; the sweep still completes at 16 cycles with the same result.
  - start in DONE: done drops the next cycle and a second sweep gives the identical result.
- rst_n asserted at cycle 9 of a sweep:
  - x, captured, busy and done go to 0 immediately, with no clock edge needed;
  - after release, the block stays in IDLE until start.
- HOLD=1, N_IN=2, EXPECT=4'h6, f=x[1]^x[0]:
  - 4 busy cycles, captured=4'h6, pass=1.
